display_scan_mux: RTL and testbench

//   Time-multiplexed scanner for a 4-digit common-anode 7-segment display.

---
 rtl/display_scan_mux.sv | 71 +++++++
 tb/tb_display_scan_mux.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// display_scan_mux: 4-digit common-anode 7-segment scanner with frame-synchronous double buffering.
// Define LEADING_ZERO_BLANK_EN to keep digits above the most-significant non-zero nibble dark.
module display_scan_mux #(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        enable,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic        frame_done
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] P_LAST  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
    localparam logic PH_BLANK = 1'b0;
    localparam logic PH_DRIVE = 1'b1;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic [15:0]   shadow_q, shadow_d, value_q, value_d;
    logic          pending_q, pending_d;
    logic [3:0]    bcd_q, bcd_d, an_q, an_d;
    logic          phase, wrap, boundary, digit_on;

    always_comb begin
        wrap       = enable && presc_q == P_LAST;
        boundary   = wrap && digit_q == 2'd3;
        phase      = presc_q < P_BLANK ? PH_BLANK : PH_DRIVE;
        presc_d    = !enable ? presc_q : wrap ? '0 : presc_q + 1'b1;
        digit_d    = wrap ? digit_q + 1'b1 : digit_q;
        shadow_d   = load ? value_in : shadow_q;
        pending_d  = boundary ? 1'b0 : (load | pending_q);
        // A load landing on the boundary itself bypasses the shadow register
        value_d    = !boundary ? value_q : load ? value_in : pending_q ? shadow_q : value_q;
`ifdef LEADING_ZERO_BLANK_EN
        digit_on   = digit_q == 2'd0 || (value_q >> {digit_q, 2'b00}) != 16'h0;
`else
        digit_on   = 1'b1;
`endif
        bcd_d      = value_q[{digit_q, 2'b00} +: 4];
        an_d       = (enable && phase == PH_DRIVE && digit_on) ? ~(4'b0001 << digit_q) : 4'b1111;
        frame_done = rst_n && boundary;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q   <= '0;
            digit_q   <= 2'd0;
            shadow_q  <= 16'h0;
            value_q   <= 16'h0;
            pending_q <= 1'b0;
            bcd_q     <= 4'h0;
            an_q      <= 4'b1111;
        end else begin
            presc_q   <= presc_d;
            digit_q   <= digit_d;
            shadow_q  <= shadow_d;
            value_q   <= value_d;
            pending_q <= pending_d;
            bcd_q     <= bcd_d;
            an_q      <= an_d;
        end
    end

    assign bcd = bcd_q;
    assign an  = an_q;
endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: vector table, directed frame/enable/bypass sequences and random traffic
// checked against a cycle-count reference model of the scanner.
module tb_display_scan_mux;
    localparam int P = 8;
    localparam int B = 2;

    logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, enable = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic [3:0]  bcd, an;
    logic        frame_done;

    int n_cmp = 0, n_bad = 0;
    int m_cnt = 0;
    logic [15:0] m_val = 0, m_sh = 0;
    bit m_pend = 0;
    logic [3:0] m_an = 4'hF, m_bcd = 4'h0;
    logic last_fd;

    typedef struct {
        bit r; bit l; logic [15:0] v; bit e; int n;
        logic [3:0] an; logic [3:0] bcd; bit fd;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    display_scan_mux #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load), .enable(enable),
        .bcd(bcd), .an(an), .frame_done(frame_done)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m_cnt counts enabled cycles since reset; slot position and digit follow by division.
    task automatic cyc(input bit r, input bit l, input logic [15:0] v, input bit e);
        int pos, dig;
        bit on, bnd;
        rst_n = r; load = l; value_in = v; enable = e;
        #1;
        last_fd = frame_done;
        chk("frame_done", frame_done, r && e && (m_cnt % (4 * P) == 4 * P - 1));
        @(posedge clk);
        if (!r) begin
            m_cnt = 0; m_val = 0; m_sh = 0; m_pend = 0; m_an = 4'hF; m_bcd = 4'h0;
        end else begin
            pos = m_cnt % P;
            dig = (m_cnt / P) % 4;
            m_bcd = 4'(m_val >> (4 * dig));
            on = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            on = dig == 0 || (m_val >> (4 * dig)) != 0;
`endif
            m_an = (e && pos >= B && on) ? 4'(~(1 << dig)) : 4'hF;
            bnd = e && pos == P - 1 && dig == 3;
            if (bnd) begin
                if (l) m_val = v;
                else if (m_pend) m_val = m_sh;
                m_pend = 0;
            end else if (l) m_pend = 1;
            if (l) m_sh = v;
            if (e) m_cnt++;
        end
        #1;
        chk("an", an, m_an);
        chk("bcd", bcd, m_bcd);
    endtask

    task automatic wait_phase(input int ph);
        int guard = 0;
        while (m_cnt % (4 * P) != ph && guard < 64) begin
            cyc(1, 0, 16'h0, 1);
            guard++;
        end
        if (m_cnt % (4 * P) != ph) begin
            n_bad++;
            $display("FAIL wait_phase: phase %0d not reached within 64 cycles", ph);
        end
    endtask

    initial begin
        int lows[4];
        int exp_lows[4];
        tbl[0] = '{0, 0, 16'h0,    0, 3,  4'b1111, 4'h0, 0};
        tbl[1] = '{1, 1, 16'h1234, 1, 1,  4'b1111, 4'h0, 0};
        tbl[2] = '{1, 0, 16'h0,    1, 30, 4'b0111, 4'h0, 0};
        tbl[3] = '{1, 0, 16'h0,    1, 1,  4'b0111, 4'h0, 1};
        tbl[4] = '{1, 0, 16'h0,    1, 1,  4'b1111, 4'h4, 0};
        tbl[5] = '{1, 0, 16'h0,    1, 2,  4'b1110, 4'h4, 0};
        tbl[6] = '{1, 0, 16'h0,    1, 8,  4'b1101, 4'h3, 0};
        tbl[7] = '{1, 0, 16'h0,    1, 8,  4'b1011, 4'h2, 0};
        tbl[8] = '{1, 0, 16'h0,    1, 8,  4'b0111, 4'h1, 0};
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].r, tbl[i].l, tbl[i].v, tbl[i].e);
            chk($sformatf("tbl%0d_an", i), an, tbl[i].an);
            chk($sformatf("tbl%0d_bcd", i), bcd, tbl[i].bcd);
            chk($sformatf("tbl%0d_fd", i), last_fd, tbl[i].fd);
        end

        // New value loaded during digit 1 stays invisible until the frame boundary
        wait_phase(10);
        cyc(1, 1, 16'hABCD, 1);
        wait_phase(20);
        cyc(1, 0, 16'h0, 1);
        chk("s3_an_d2", an, 4'b1011);
        chk("s3_bcd_d2_old", bcd, 4'h2);
        wait_phase(2);
        cyc(1, 0, 16'h0, 1);
        chk("s3_an_d0", an, 4'b1110);
        chk("s3_bcd_d0_new", bcd, 4'hD);

        // Freeze mid-DRIVE of digit 2, then resume at the same slot position
        wait_phase(20);
        cyc(1, 0, 16'h0, 0);
        chk("s4_an_off", an, 4'b1111);
        for (int k = 0; k < 9; k++) cyc(1, 0, 16'h0, 0);
        chk("s4_an_off_end", an, 4'b1111);
        cyc(1, 0, 16'h0, 1);
        chk("s4_an_resume", an, 4'b1011);
        chk("s4_bcd_resume", bcd, 4'hB);

        // Load on the frame_done cycle takes effect in the very next frame
        wait_phase(31);
        cyc(1, 1, 16'h5A5A, 1);
        chk("s5_fd", last_fd, 1'b1);
        wait_phase(2);
        cyc(1, 0, 16'h0, 1);
        chk("s5_an_d0", an, 4'b1110);
        chk("s5_bcd_d0", bcd, 4'hA);
        wait_phase(10);
        cyc(1, 0, 16'h0, 1);
        chk("s5_an_d1", an, 4'b1101);
        chk("s5_bcd_d1", bcd, 4'h5);

        // Anode activity over a whole frame showing 0x0040
        cyc(1, 1, 16'h0040, 1);
        wait_phase(31);
        cyc(1, 0, 16'h0, 1);
        lows = '{0, 0, 0, 0};
        for (int k = 0; k < 4 * P; k++) begin
            cyc(1, 0, 16'h0, 1);
            for (int j = 0; j < 4; j++) if (!an[j]) lows[j]++;
        end
`ifdef LEADING_ZERO_BLANK_EN
        exp_lows = '{P - B, P - B, 0, 0};
`else
        exp_lows = '{P - B, P - B, P - B, P - B};
`endif
        for (int j = 0; j < 4; j++) chk($sformatf("s6_lows_an%0d", j), 16'(lows[j]), 16'(exp_lows[j]));

        for (int k = 0; k < 800; k++)
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 7) == 0,
                16'($urandom), $urandom_range(0, 9) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
